// File: rtl/gesture_window_scheduler.sv
// ----------------------------------------------------------------------------
// gesture_window_scheduler: gates DVS events into windows, fires one compute
// per window and waits for the classifier result.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gesture_window_scheduler #(
  parameter int TS_BITS        = 16,
  parameter int CNT_BITS       = 16,
  parameter int RESULT_TIMEOUT = 64,
  parameter int DROP_CNT_BITS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [CNT_BITS-1:0]      cfg_window_events,
  input  logic [TS_BITS-1:0]       cfg_window_ts,
  input  logic [CNT_BITS-1:0]      cfg_min_events,
  input  logic                     in_valid,
  input  logic [TS_BITS-1:0]       in_ts,
  output logic                     in_ready,
  output logic                     acc_event_valid,
  output logic                     acc_compute_trigger,
  output logic                     acc_clear,
  input  logic                     cls_gesture_valid,
  input  logic [1:0]               cls_gesture,
  output logic [1:0]               out_gesture,
  output logic                     out_gesture_valid,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [DROP_CNT_BITS-1:0] drop_count
);

  localparam int WAIT_BITS = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;
  localparam logic [WAIT_BITS-1:0] C_WAIT_LAST = WAIT_BITS'(RESULT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_TRIGGER = 3'd2,
    S_WAIT    = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t                   state_q;
  logic [CNT_BITS-1:0]      ev_cnt_q;
  logic [TS_BITS-1:0]       first_ts_q;
  logic [WAIT_BITS-1:0]     wait_cnt_q;
  logic [CNT_BITS-1:0]      win_events_q;
  logic [TS_BITS-1:0]       win_ts_q;
  logic [CNT_BITS-1:0]      min_events_q;
  logic                     trig_q;
  logic                     clear_q;
  logic                     gvalid_q;
  logic [1:0]               gesture_q;
  logic                     terr_q;
  logic [DROP_CNT_BITS-1:0] drop_q;

  logic                     accept;
  logic [CNT_BITS:0]        ev_next;
  logic [TS_BITS-1:0]       span;
  logic                     close_cnt;
  logic                     close_ts;
  logic                     close;
  logic                     min_ok;
  logic [CNT_BITS-1:0]      cfg_events_eff;
  logic [DROP_CNT_BITS-1:0] drop_inc;

  always_comb begin
    accept         = in_valid & in_ready;
    ev_next        = {1'b0, ev_cnt_q} + 1'b1;
    span           = in_ts - first_ts_q;
    close_cnt      = (ev_next == {1'b0, win_events_q});
    close_ts       = (win_ts_q != '0) && (ev_cnt_q != '0) && (span >= win_ts_q);
    close          = accept & (close_cnt | close_ts);
    min_ok         = (ev_next >= {1'b0, min_events_q});
    cfg_events_eff = (cfg_window_events == '0) ? CNT_BITS'(1) : cfg_window_events;
    drop_inc       = (&drop_q) ? drop_q : drop_q + 1'b1;
  end

  // Shadows track the inputs everywhere except COLLECT, so the value present
  // on the last cycle before entering COLLECT is what the window uses.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_events_q <= '0;
      win_ts_q     <= '0;
      min_events_q <= '0;
    end else if (state_q != S_COLLECT) begin
      win_events_q <= cfg_events_eff;
      win_ts_q     <= cfg_window_ts;
      min_events_q <= cfg_min_events;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ev_cnt_q   <= '0;
      first_ts_q <= '0;
      wait_cnt_q <= '0;
      trig_q     <= 1'b0;
      clear_q    <= 1'b0;
      gvalid_q   <= 1'b0;
      gesture_q  <= '0;
      terr_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      trig_q   <= 1'b0;
      clear_q  <= 1'b0;
      gvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) state_q <= S_COLLECT;
        end
        S_COLLECT: begin
          if (accept) begin
            ev_cnt_q <= ev_next[CNT_BITS-1:0];
            if (ev_cnt_q == '0) first_ts_q <= in_ts;
          end
          // A closing event wins over a simultaneous stop request.
          if (close) begin
            ev_cnt_q <= '0;
            if (min_ok) begin
              state_q <= S_TRIGGER;
              trig_q  <= 1'b1;
            end else begin
              state_q <= S_DROP;
              clear_q <= 1'b1;
            end
          end else if (!enable) begin
            ev_cnt_q <= '0;
            clear_q  <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        S_TRIGGER: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (cls_gesture_valid) begin
            gesture_q <= cls_gesture;
            gvalid_q  <= 1'b1;
            state_q   <= enable ? S_COLLECT : S_IDLE;
          end else if (wait_cnt_q == C_WAIT_LAST) begin
            terr_q  <= 1'b1;
            clear_q <= 1'b1;
            drop_q  <= drop_inc;
            state_q <= enable ? S_COLLECT : S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_DROP: begin
          drop_q  <= drop_inc;
          state_q <= enable ? S_COLLECT : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready            = (state_q == S_COLLECT);
  assign acc_event_valid     = in_valid & in_ready;
  assign acc_compute_trigger = trig_q;
  assign acc_clear           = clear_q;
  assign out_gesture         = gesture_q;
  assign out_gesture_valid   = gvalid_q;
  assign busy                = (state_q == S_TRIGGER) || (state_q == S_WAIT) || (state_q == S_DROP);
  assign timeout_err         = terr_q;
  assign drop_count          = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_gesture_window_scheduler.sv
// ----------------------------------------------------------------------------
// tb_gesture_window_scheduler: directed scenarios plus randomized windows
// checked against an event-level reference model.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_gesture_window_scheduler;

  localparam int TS_BITS        = 16;
  localparam int CNT_BITS       = 16;
  localparam int RESULT_TIMEOUT = 8;
  localparam int DROP_CNT_BITS  = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     enable;
  logic [CNT_BITS-1:0]      cfg_window_events;
  logic [TS_BITS-1:0]       cfg_window_ts;
  logic [CNT_BITS-1:0]      cfg_min_events;
  logic                     in_valid;
  logic [TS_BITS-1:0]       in_ts;
  logic                     in_ready;
  logic                     acc_event_valid;
  logic                     acc_compute_trigger;
  logic                     acc_clear;
  logic                     cls_gesture_valid;
  logic [1:0]               cls_gesture;
  logic [1:0]               out_gesture;
  logic                     out_gesture_valid;
  logic                     busy;
  logic                     timeout_err;
  logic [DROP_CNT_BITS-1:0] drop_count;

  gesture_window_scheduler #(
    .TS_BITS(TS_BITS), .CNT_BITS(CNT_BITS),
    .RESULT_TIMEOUT(RESULT_TIMEOUT), .DROP_CNT_BITS(DROP_CNT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_window_events(cfg_window_events), .cfg_window_ts(cfg_window_ts),
    .cfg_min_events(cfg_min_events),
    .in_valid(in_valid), .in_ts(in_ts), .in_ready(in_ready),
    .acc_event_valid(acc_event_valid), .acc_compute_trigger(acc_compute_trigger),
    .acc_clear(acc_clear), .cls_gesture_valid(cls_gesture_valid),
    .cls_gesture(cls_gesture), .out_gesture(out_gesture),
    .out_gesture_valid(out_gesture_valid), .busy(busy),
    .timeout_err(timeout_err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: latched window config and observable sticky state.
  int         m_we, m_wt, m_min;
  int         m_drops;
  logic       m_terr;
  logic [1:0] m_gest;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int we, input int wt, input int mn);
    m_we = we; m_wt = wt; m_min = mn;
    cfg_window_events = CNT_BITS'(we);
    cfg_window_ts     = TS_BITS'(wt);
    cfg_min_events    = CNT_BITS'(mn);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, in_ready, 0);
    check_val({tag, "_trig"}, acc_compute_trigger, 0);
    check_val({tag, "_clear"}, acc_clear, 0);
    check_val({tag, "_gest"}, {out_gesture_valid, out_gesture}, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_terr"}, timeout_err, 0);
    check_val({tag, "_drops"}, drop_count, 0);
  endtask

  // Returns to IDLE via enable low, then enters COLLECT with new config.
  task automatic restart(input int we, input int wt, input int mn);
    enable = 1'b0;
    tick();
    tick();
    set_cfg(we, wt, mn);
    enable = 1'b1;
    tick();
    check_val("restart_ready", in_ready, 1);
  endtask

  task automatic send_ev(input logic [15:0] ts);
    in_valid = 1'b1;
    in_ts    = ts;
    #1;
    check_val("ev_accept", acc_event_valid, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Called on the TRIGGER cycle; answers on WAIT cycle d or lets it time out.
  task automatic serve_wait(input int d, input logic [1:0] g);
    tick();
    for (int k = 0; k < RESULT_TIMEOUT; k++) begin
      check_val("wait_state", {busy, in_ready, acc_compute_trigger}, 3'b100);
      if (k == d) begin
        cls_gesture_valid = 1'b1;
        cls_gesture       = g;
        tick();
        cls_gesture_valid = 1'b0;
        m_gest = g;
        check_val("result_out", {out_gesture_valid, out_gesture}, {1'b1, g});
        check_val("result_ready", in_ready, enable);
        return;
      end
      tick();
    end
    m_terr = 1'b1;
    if (m_drops < 255) m_drops++;
    check_val("timeout_clear", acc_clear, 1);
    check_val("timeout_err", timeout_err, 1);
    check_val("timeout_drops", drop_count, m_drops);
    check_val("timeout_gest", {out_gesture_valid, out_gesture}, {1'b0, m_gest});
    check_val("timeout_ready", in_ready, enable);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] cur_ts, first_ts, span;
    int          n, guard;
    bit          closed;
    int          we_eff;

    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_ts = '0;
    cls_gesture_valid = 1'b0; cls_gesture = '0;
    set_cfg(1, 0, 0);
    m_drops = 0; m_terr = 1'b0; m_gest = '0;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");
    tick();
    check_val("idle_ready", in_ready, 0);

    // Count-closed window followed by an immediate result.
    restart(4, 0, 1);
    for (int i = 0; i < 4; i++) begin
      check_val("count_notrig", acc_compute_trigger, 0);
      send_ev(16'(i * 3));
    end
    check_val("count_trig", acc_compute_trigger, 1);
    check_val("count_ready_low", in_ready, 0);
    serve_wait(0, 2'd2);

    // Time closure across timestamp wrap.
    restart(100, 50, 1);
    send_ev(16'hFFF0);
    send_ev(16'hFFFA);
    check_val("wrap_notrig", acc_compute_trigger, 0);
    send_ev(16'h0022);
    check_val("wrap_trig", acc_compute_trigger, 1);
    serve_wait(2, 2'd1);

    // Under-populated window is dropped.
    restart(100, 10, 5);
    send_ev(16'd0);
    send_ev(16'd20);
    check_val("drop_clear", acc_clear, 1);
    check_val("drop_trig", acc_compute_trigger, 0);
    check_val("drop_busy", busy, 1);
    tick();
    m_drops++;
    check_val("drop_count", drop_count, m_drops);
    check_val("drop_ready", in_ready, 1);

    // Result timeout, then a stray result in COLLECT must be ignored.
    restart(4, 0, 1);
    for (int i = 0; i < 4; i++) send_ev(16'(100 + i));
    check_val("to_trig", acc_compute_trigger, 1);
    serve_wait(RESULT_TIMEOUT + 5, 2'd0);
    cls_gesture_valid = 1'b1;
    cls_gesture       = 2'd3;
    tick();
    cls_gesture_valid = 1'b0;
    check_val("stray_ignored", {out_gesture_valid, out_gesture}, {1'b0, m_gest});

    // Stop mid-window, then a full window after re-enable.
    restart(4, 0, 1);
    send_ev(16'd1);
    send_ev(16'd2);
    enable = 1'b0;
    tick();
    check_val("stop_clear", acc_clear, 1);
    check_val("stop_ready", in_ready, 0);
    check_val("stop_busy", busy, 0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_val("rearm_notrig", acc_compute_trigger, 0);
      send_ev(16'(10 + i));
    end
    check_val("rearm_trig", acc_compute_trigger, 1);
    serve_wait(1, 2'd3);
    check_val("rearm_drops", drop_count, m_drops);

    // Reset while waiting for the classifier.
    for (int i = 0; i < 4; i++) send_ev(16'(20 + i));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_drops = 0; m_terr = 1'b0; m_gest = '0;
    check_all_zero("rst_wait");

    // Randomized windows with config scrambled while collecting.
    restart($urandom_range(0, 8), ($urandom_range(0, 1) != 0) ? $urandom_range(1, 40) : 0,
            $urandom_range(0, 6));
    cur_ts = 16'($urandom);
    for (int w = 0; w < 200; w++) begin
      n = 0; guard = 0; closed = 1'b0; first_ts = '0;
      we_eff = (m_we == 0) ? 1 : m_we;
      while (!closed && guard < 200) begin
        guard++;
        in_valid = ($urandom_range(0, 3) != 0);
        in_ts    = cur_ts;
        cfg_window_events = 16'($urandom);
        cfg_window_ts     = 16'($urandom);
        cfg_min_events    = 16'($urandom);
        cls_gesture_valid = ($urandom_range(0, 7) == 0);
        cls_gesture       = 2'($urandom);
        #1;
        check_val("rnd_ready", in_ready, 1);
        check_val("rnd_accept", acc_event_valid, in_valid);
        if (in_valid) begin
          n++;
          if (n == 1) first_ts = in_ts;
          span = in_ts - first_ts;
          closed = (n == we_eff) || (m_wt != 0 && n >= 2 && int'(span) >= m_wt);
          cur_ts = cur_ts + 16'($urandom_range(0, 15));
        end
        tick();
        in_valid = 1'b0;
        cls_gesture_valid = 1'b0;
        if (!closed) begin
          check_val("rnd_idle_out", {acc_compute_trigger, acc_clear, out_gesture_valid, out_gesture},
                    {3'b000, m_gest});
        end
      end
      check_val("rnd_window_closed", closed, 1);
      if (n >= m_min) begin
        check_val("rnd_trig", {acc_compute_trigger, acc_clear, busy}, 3'b101);
        set_cfg($urandom_range(0, 8), ($urandom_range(0, 1) != 0) ? $urandom_range(1, 40) : 0,
                $urandom_range(0, 6));
        serve_wait($urandom_range(0, 10), 2'($urandom));
      end else begin
        check_val("rnd_drop", {acc_compute_trigger, acc_clear, busy}, 3'b011);
        set_cfg($urandom_range(0, 8), ($urandom_range(0, 1) != 0) ? $urandom_range(1, 40) : 0,
                $urandom_range(0, 6));
        tick();
        if (m_drops < 255) m_drops++;
        check_val("rnd_drop_count", drop_count, m_drops);
        check_val("rnd_drop_ready", in_ready, 1);
      end
      check_val("rnd_terr", timeout_err, m_terr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
